// File: rtl/weight_controller_pkg.sv
// Shared definitions for the weight path: controller states, fetch geometry
// and the kernel base-address arithmetic.
package winocnn_pkg;
  localparam int WC_DATA_W   = 8;
  localparam int WC_ADDR_W   = 16;
  localparam int KERNEL_TAPS = 9;
  localparam int WFETCH_LEN  = 18;

  typedef enum logic [1:0] {IDLE, FETCH, READY, ACTIVE} wctrl_state_t;

  // Kernels are stored od-major, then id, 9 taps each.
  // The linear index is 12 bits and the *9 product is 16 bits.
  function automatic logic [15:0] kernel_base(input logic [7:0] od,
                                              input logic [3:0] tid,
                                              input logic [3:0] id);
    logic [11:0] lin;
    lin = 12'(od) * 12'(tid) + 12'(id);
    return 16'(lin) * 16'd9;
  endfunction
endpackage

// File: rtl/weight_controller_if.sv
// Weight memory read port: synchronous read, data one cycle after mem_ren_o.
interface weight_controller_if import winocnn_pkg::*; #(
  parameter int DATA_W = WC_DATA_W,
  parameter int ADDR_W = WC_ADDR_W
);
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ren_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (output mem_addr_o, output mem_ren_o, input mem_rdata_i);
  modport slave  (input mem_addr_o, input mem_ren_o, output mem_rdata_i);
endinterface

// File: rtl/weight_controller_addr_gen.sv
// Registers both kernel base addresses at fetch launch and maps a fetch slot
// to its read address and read enable.
module weight_addr_gen import winocnn_pkg::*; #(
  parameter int ADDR_W = WC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              launch,
  input  logic [7:0]        od1,
  input  logic [7:0]        od2,
  input  logic [3:0]        id,
  input  logic [3:0]        total_id,
  input  logic [7:0]        total_od,
  input  logic [4:0]        slot,
  output logic [ADDR_W-1:0] addr,
  output logic              ren,
  output logic              od2_ok
);
  logic [ADDR_W-1:0] base1_q, base2_q;
  logic              second;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base1_q <= '0;
      base2_q <= '0;
      od2_ok  <= 1'b0;
    end else if (launch) begin
      base1_q <= ADDR_W'(kernel_base(od1, total_id, id));
      base2_q <= ADDR_W'(kernel_base(od2, total_id, id));
      od2_ok  <= (od2 < total_od);
    end
  end

  assign second = (slot >= 5'(KERNEL_TAPS));

  // An out-of-range od2 still walks its slots so the fetch length stays fixed.
  always_comb begin
    addr = second ? base2_q + ADDR_W'(slot - 5'(KERNEL_TAPS))
                  : base1_q + ADDR_W'(slot);
    ren  = !second || od2_ok;
  end
endmodule

// File: rtl/weight_controller.sv
// Fetches the od1/od2 kernel pair into a shadow buffer and presents it to the
// PE array on start; the next pair can be fetched while the current one holds.
module weight_controller import winocnn_pkg::*; #(
  parameter int DATA_W = WC_DATA_W,
  parameter int ADDR_W = WC_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    total_id_i,
  input  logic [7:0]                    total_od_i,
  input  logic [7:0]                    weight_od1_i,
  input  logic [7:0]                    weight_od2_i,
  input  logic [3:0]                    weight_id_i,
  input  logic                          weight_prepare_i,
  input  logic                          weight_start_i,
  output logic                          weight_ready_o,
  weight_controller_if.master           mem,
  output logic [KERNEL_TAPS*DATA_W-1:0] kernel1_o,
  output logic [KERNEL_TAPS*DATA_W-1:0] kernel2_o,
  output logic                          kernel_valid_o
);
  wctrl_state_t state_q, state_d;
  logic         launch;
  logic [4:0]   cnt_q;
  logic [4:0]   cap_slot;
  logic [WFETCH_LEN-1:0][DATA_W-1:0] shadow_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_ren;
  logic              od2_ok;

  weight_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .launch   (launch),
    .od1      (weight_od1_i),
    .od2      (weight_od2_i),
    .id       (weight_id_i),
    .total_id (total_id_i),
    .total_od (total_od_i),
    .slot     (cnt_q),
    .addr     (gen_addr),
    .ren      (gen_ren),
    .od2_ok   (od2_ok)
  );

  // Slot k issues when cnt==k and its data is captured two edges later.
  assign cap_slot = cnt_q - 5'd2;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE:   if (weight_prepare_i) begin launch = 1'b1; state_d = FETCH; end
      FETCH:  if (cnt_q == 5'(WFETCH_LEN + 1)) state_d = READY;
      READY:  if (weight_start_i) state_d = ACTIVE;
      ACTIVE: if (weight_prepare_i) begin launch = 1'b1; state_d = FETCH; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      mem.mem_addr_o <= '0;
      mem.mem_ren_o  <= 1'b0;
      weight_ready_o <= 1'b0;
      kernel1_o      <= '0;
      kernel2_o      <= '0;
      kernel_valid_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      weight_ready_o <= (state_d == READY);
      kernel_valid_o <= (state_d == ACTIVE) && weight_start_i;
      mem.mem_ren_o  <= 1'b0;

      if (launch)                cnt_q <= '0;
      else if (state_q == FETCH) cnt_q <= cnt_q + 5'd1;

      if (state_q == FETCH && cnt_q < 5'(WFETCH_LEN)) begin
        mem.mem_addr_o <= gen_addr;
        mem.mem_ren_o  <= gen_ren;
      end

      if (state_q == FETCH && cnt_q >= 5'd2)
        shadow_q[cap_slot] <= (cap_slot < 5'(KERNEL_TAPS) || od2_ok) ? mem.mem_rdata_i : '0;

      if (state_q == READY && weight_start_i) begin
        kernel1_o <= shadow_q[KERNEL_TAPS-1:0];
        kernel2_o <= shadow_q[WFETCH_LEN-1:KERNEL_TAPS];
      end
    end
  end
endmodule

// File: tb/tb_weight_controller.sv
// Directed bench for weight_controller: memory returns addr[7:0] one cycle
// after each read; expected bases are hand-computed per step.
module tb_weight_controller;
  import winocnn_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  total_id_i;
  logic [7:0]  total_od_i;
  logic [7:0]  weight_od1_i, weight_od2_i;
  logic [3:0]  weight_id_i;
  logic        weight_prepare_i, weight_start_i;
  logic        weight_ready_o, kernel_valid_o;
  logic [71:0] kernel1_o, kernel2_o;
  int          tests = 0;
  int          fails = 0;

  weight_controller_if #(.DATA_W(8), .ADDR_W(16)) mif ();

  weight_controller #(.DATA_W(8), .ADDR_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .total_id_i       (total_id_i),
    .total_od_i       (total_od_i),
    .weight_od1_i     (weight_od1_i),
    .weight_od2_i     (weight_od2_i),
    .weight_id_i      (weight_id_i),
    .weight_prepare_i (weight_prepare_i),
    .weight_start_i   (weight_start_i),
    .weight_ready_o   (weight_ready_o),
    .mem              (mif),
    .kernel1_o        (kernel1_o),
    .kernel2_o        (kernel2_o),
    .kernel_valid_o   (kernel_valid_o)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (mif.mem_ren_o) mif.mem_rdata_i <= mif.mem_addr_o[7:0];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] kern(input logic [15:0] base);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'(base + 16'(k));
    return r;
  endfunction

  // Launch a fetch and check every slot plus the ready edge.
  task automatic do_fetch(input logic [7:0] o1, input logic [7:0] o2, input logic [3:0] i,
                          input logic [3:0] t_id, input logic [7:0] t_od,
                          input logic [15:0] b1, input logic [15:0] b2, input bit sup,
                          input int abort_at, input bit violate);
    logic [15:0] ea;
    weight_od1_i = o1; weight_od2_i = o2; weight_id_i = i;
    total_id_i = t_id; total_od_i = t_od;
    weight_prepare_i = 1'b1;
    @(posedge clk); @(negedge clk);
    weight_prepare_i = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); @(negedge clk);
      ea = (k < 9) ? b1 + 16'(k) : b2 + 16'(k - 9);
      if (k < 9 || !sup)
        chk($sformatf("slot%0d", k), 128'({mif.mem_ren_o, mif.mem_addr_o}), 128'({1'b1, ea}));
      else
        chk($sformatf("slot%0d_sup", k), 128'(mif.mem_ren_o), 128'(0));
      if (k == abort_at) return;
      if (violate && k == 3) begin
        weight_start_i = 1'b1; weight_prepare_i = 1'b1;
        weight_od1_i = 8'd9; weight_id_i = 4'd3;
      end
      if (violate && k == 6) begin
        weight_start_i = 1'b0; weight_prepare_i = 1'b0;
      end
    end
    @(posedge clk); @(negedge clk);
    chk("ready_e19", 128'(weight_ready_o), 128'(0));
    chk("ren_idle", 128'(mif.mem_ren_o), 128'(0));
    @(posedge clk); @(negedge clk);
    chk("ready_e20", 128'(weight_ready_o), 128'(1));
  endtask

  task automatic do_start(input logic [71:0] e1, input logic [71:0] e2);
    weight_start_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_drop", 128'(weight_ready_o), 128'(0));
    chk("valid_rise", 128'(kernel_valid_o), 128'(1));
    chk("kernel1", 128'(kernel1_o), 128'(e1));
    chk("kernel2", 128'(kernel2_o), 128'(e2));
    weight_start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("valid_fall", 128'(kernel_valid_o), 128'(0));
    chk("kernel1_hold", 128'(kernel1_o), 128'(e1));
  endtask

  initial begin
    reset = 1'b0;
    total_id_i = '0; total_od_i = '0; weight_od1_i = '0; weight_od2_i = '0;
    weight_id_i = '0; weight_prepare_i = 1'b0; weight_start_i = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_ctl", 128'({weight_ready_o, mif.mem_ren_o, mif.mem_addr_o, kernel_valid_o}), 128'(0));
    chk("rst_k1", 128'(kernel1_o), 128'(0));
    chk("rst_k2", 128'(kernel2_o), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // basic: base1=(0*2+1)*9=9, base2=(1*2+1)*9=27
    do_fetch(8'd0, 8'd1, 4'd1, 4'd2, 8'd4, 16'd9, 16'd27, 1'b0, -1, 1'b0);
    do_start(kern(16'd9), kern(16'd27));

    // overlap: id=0 -> bases 0/18, then prefetch id=1 from ACTIVE
    do_fetch(8'd0, 8'd1, 4'd0, 4'd2, 8'd4, 16'd0, 16'd18, 1'b0, -1, 1'b0);
    do_start(kern(16'd0), kern(16'd18));
    do_fetch(8'd0, 8'd1, 4'd1, 4'd2, 8'd4, 16'd9, 16'd27, 1'b0, -1, 1'b0);
    chk("ovl_k1_held", 128'(kernel1_o), 128'(kern(16'd0)));
    chk("ovl_k2_held", 128'(kernel2_o), 128'(kern(16'd18)));
    do_start(kern(16'd9), kern(16'd27));

    // odd total_od: od2=3 out of range; base1=(2*2+1)*9=45, base2=(3*2+1)*9=63
    do_fetch(8'd2, 8'd3, 4'd1, 4'd2, 8'd3, 16'd45, 16'd63, 1'b1, -1, 1'b0);
    do_start(kern(16'd45), 72'd0);

    // reset during slot 7
    do_fetch(8'd0, 8'd1, 4'd1, 4'd2, 8'd4, 16'd9, 16'd27, 1'b0, 7, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_ctl", 128'({weight_ready_o, mif.mem_ren_o, mif.mem_addr_o, kernel_valid_o}), 128'(0));
    chk("arst_k1", 128'(kernel1_o), 128'(0));
    chk("arst_k2", 128'(kernel2_o), 128'(0));
    chk("arst_state", 128'(dut.state_q), 128'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_fetch(8'd0, 8'd1, 4'd1, 4'd2, 8'd4, 16'd9, 16'd27, 1'b0, -1, 1'b0);
    do_start(kern(16'd9), kern(16'd27));

    // start/prepare/od/id wiggled mid-fetch must not disturb anything
    do_fetch(8'd0, 8'd1, 4'd0, 4'd2, 8'd4, 16'd0, 16'd18, 1'b0, -1, 1'b1);
    chk("viol_k1_held", 128'(kernel1_o), 128'(kern(16'd9)));
    chk("viol_k2_held", 128'(kernel2_o), 128'(kern(16'd27)));
    do_start(kern(16'd0), kern(16'd18));

    // extremes: base1=(254*15+14)*9=34416, od2=255 not < 255
    do_fetch(8'd254, 8'd255, 4'd14, 4'd15, 8'd255, 16'd34416, 16'd34551, 1'b1, -1, 1'b0);
    do_start(kern(16'd34416), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/weight_controller.md
# weight_controller

Fetches the two 3x3 kernels for output channels od1/od2 at input channel id from the off-chip weight memory into a shadow buffer, and presents them to the PE array. It sits directly downstream of the main controller's weight interface (prepare/start/ready handshake). Double buffering lets the next fetch proceed while the current kernels stay stable on the outputs.

## Interface
- DATA_W, 8, weight word width
- ADDR_W, 16, weight memory address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- total_id_i  in  4  number of input channels; sampled at each fetch launch
- total_od_i  in  8  number of output channels; sampled at each fetch launch
- weight_od1_i  in  8  first output channel of the pair
- weight_od2_i  in  8  second output channel (od1+1)
- weight_id_i  in  4  input channel
- weight_prepare_i  in  1  request to fetch the kernels for the current od1/od2/id
- weight_start_i  in  1  compute phase active
- weight_ready_o  out  1  shadow buffer holds the requested kernels
- mem_addr_o  out  ADDR_W  weight memory read address
- mem_ren_o  out  1  weight memory read enable
- mem_rdata_i  in  DATA_W  read data, valid exactly 1 cycle after a read issued with mem_ren_o=1
- kernel1_o  out  9*DATA_W  od1 kernel; tap k = row*3+col at [DATA_W*k +: DATA_W]
- kernel2_o  out  9*DATA_W  od2 kernel, same packing
- kernel_valid_o  out  1  kernel outputs belong to the current compute phase

## Operation
- States: IDLE, FETCH, READY, ACTIVE.
- IDLE: if weight_prepare_i=1, latch od1, od2, id, total_id_i and total_od_i; compute base1 = (od1*total_id + id)*9 and base2 = (od2*total_id + id)*9, both truncated to ADDR_W; clear the fetch counter; go to FETCH.
- FETCH: the counter k runs from 0 to 17, one issue per cycle.
  - For k<9: addr = base1+k.
  - For k>=9: addr = base2+(k-9).
  - The response for slot k is written into shadow[k] one cycle later.
  - If od2 >= latched total_od, slots 9..17 issue with mem_ren_o=0 and write 0 into the shadow, so fetch length is constant.
  - After the slot-17 response is captured, go to READY.
- READY: weight_ready_o=1. weight_prepare_i staying high is ignored. If weight_start_i=1, copy shadow to kernel1_o/kernel2_o and go to ACTIVE.
- ACTIVE: kernel_valid_o=1 while weight_start_i=1. Kernel outputs hold their values through the compute phase and the following idle period. If weight_prepare_i=1, launch a new fetch exactly as in IDLE (latch and compute bases), then go to FETCH. Kernel outputs remain unchanged until the next READY->ACTIVE transition.
- Arithmetic: od*total_id is a 12-bit product. The sum with id fits in 12 bits. The *9 product is computed in 16 bits, and address additions wrap modulo 2^ADDR_W.
- Protocol violations:
  - weight_start_i during FETCH is ignored (kernels are not updated).
  - weight_prepare_i during FETCH is ignored (latched parameters stay fixed).

## Timing
- Reset (asynchronous):
  - State goes to IDLE; the counter, shadow buffer and all outputs are set to 0.
  - weight_ready_o=0, mem_ren_o=0, mem_addr_o=0, kernel1_o/kernel2_o=0, kernel_valid_o=0.
  - A fetch in progress is discarded. Responses returning after reset is released are not captured.
- Fetch launch:
  - Edge E samples weight_prepare_i=1; the bases are registered at E.
  - mem_ren_o/mem_addr_o for slot k are driven during cycle E+1+k, for k = 0..17.
  - weight_ready_o is high from edge E+20 onward.
- weight_ready_o deasserts on the edge that samples weight_start_i=1.
- kernel1_o/kernel2_o update on that same edge, and kernel_valid_o rises with them.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package winocnn_pkg:
  - wctrl_state_t enum (IDLE, FETCH, READY, ACTIVE)
  - KERNEL_TAPS=9
  - WFETCH_LEN=18
  - the DATA_W/ADDR_W defaults
- One natural sub-module: weight_addr_gen. It computes base1/base2 with the registered multiply and produces the per-slot address and read-enable, including the od2-out-of-range suppression.

## Test plan
- Basic fetch, total_id=2, total_od=4, od1=0, od2=1, id=1, memory loaded with mem[a]=a[7:0]:
  - addresses 9..17 then 27..35 are issued;
  - ready rises at E+20;
  - after start, kernel1 tap k = 9+k and kernel2 tap k = 27+k.
- Odd total_od=3, od1=2, od2=3:
  - mem_ren_o=0 for slots 9..17;
  - kernel2_o=0;
  - ready still rises at E+20.
- Overlap: in ACTIVE with kernels from id=0, pulse prepare for id=1:
  - kernel outputs unchanged through FETCH and READY;
  - the new values appear only on the start edge.
- Reset asserted at slot 7 of a fetch:
  - all outputs are 0 immediately;
  - state is IDLE;
  - a later prepare produces a correct, full fetch.
- Protocol violation: start and prepare toggled during FETCH:
  - no change to kernels or latched od/id;
  - ready timing unchanged.
- Address extremes, total_id=15, od1=254, od2=255, id=14, total_od=255:
  - base1 = (254*15+14)*9 = 34416;
  - od2 is out of range, so slots 9..17 are suppressed.
